// File: rtl/ltssm_pkg.sv
// Shared substate codes and sequencer state encoding
// for the receive-side LTSSM sequencer.
package ltssm_pkg;

  localparam logic [4:0] DETECT_QUIET            = 5'd0;
  localparam logic [4:0] DETECT_ACTIVE           = 5'd1;
  localparam logic [4:0] POLLING_ACTIVE          = 5'd2;
  localparam logic [4:0] POLLING_CONFIG          = 5'd3;
  localparam logic [4:0] CONFIG_LINKWIDTH_START  = 5'd4;
  localparam logic [4:0] CONFIG_LINKWIDTH_ACCEPT = 5'd5;
  localparam logic [4:0] CONFIG_LANENUM_WAIT     = 5'd6;
  localparam logic [4:0] CONFIG_LANENUM_ACCEPT   = 5'd7;
  localparam logic [4:0] CONFIG_COMPLETE         = 5'd8;
  localparam logic [4:0] CONFIG_IDLE             = 5'd9;
  localparam logic [4:0] RECOVERY_RCVRLOCK       = 5'd10;
  localparam logic [4:0] RECOVERY_SPEED          = 5'd11;
  localparam logic [4:0] RECOVERY_EQ             = 5'd12;
  localparam logic [4:0] RECOVERY_RCVRCFG        = 5'd13;
  localparam logic [4:0] RECOVERY_IDLE           = 5'd14;
  localparam logic [4:0] L0                      = 5'd15;
  localparam logic [4:0] SUBSTATE_MAX            = 5'd15;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    WAIT,
    LINKUP,
    FAIL
  } seqState_t;

  function automatic logic isLegal(input logic [4:0] code);
    return code <= SUBSTATE_MAX;
  endfunction

endpackage

// File: rtl/ltssm_watchdog.sv
// Per-substate residency counter; expire is high on the
// last allowed cycle so the sequencer can leave on that edge.
module ltssm_watchdog #(
  parameter int WAIT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/ltssm_rx_sequencer.sv
// Drives the Rx datapath substate, commits negotiated link
// parameters and guards against stuck or looping training.
module ltssm_rx_sequencer
  import ltssm_pkg::*;
#(
  parameter int WAIT_CYCLES = 4096,
  parameter int MAX_HOPS    = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rx_finish,
  input  logic [4:0]       rx_exit_to,
  input  logic             rx_write_rate_id,
  input  logic             rx_write_link_number,
  input  logic [7:0]       rx_rate_id,
  input  logic [7:0]       rx_link_number,
  input  logic             rx_upcfg,
  output logic [4:0]       substate,
  output logic             rx_reset,
  output logic [7:0]       rate_id,
  output logic [7:0]       link_number,
  output logic             upconfigure_capability,
  output logic             link_up,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam logic [HW-1:0] HOP_LIMIT = HW'(MAX_HOPS);

  seqState_t state;
  seqState_t nState;
  logic [4:0] nTarget;
  logic [HW-1:0] hops;
  logic [HW-1:0] nHops;
  logic [HW-1:0] hopsInc;
  logic wrRate;
  logic wrLink;
  logic toInc;
  logic legal;
  logic expire;

  ltssm_watchdog #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) uWatchdog (
    .clk   (clk),
    .reset (reset),
    .clear (state == ENTER),
    .enable(state == WAIT),
    .expire(expire)
  );

  assign legal   = isLegal(rx_exit_to);
  assign hopsInc = hops + HW'(1);

  always_comb begin
    nState  = state;
    nTarget = substate;
    nHops   = hops;
    wrRate  = 1'b0;
    wrLink  = 1'b0;
    toInc   = 1'b0;
    unique case (state)
      IDLE: begin
        nHops = '0;
        if (enable) begin
          nState  = ENTER;
          nTarget = DETECT_QUIET;
        end
      end
      ENTER: nState = WAIT;
      WAIT: begin
        if (rx_finish) begin
          if (!legal) begin
            nState = FAIL;
          end else begin
            wrRate = rx_write_rate_id;
            wrLink = rx_write_link_number;
            nHops  = hopsInc;
            if (rx_exit_to == L0) begin
              nState = LINKUP;
              nHops  = '0;
            end else if (hopsInc == HOP_LIMIT) begin
              nState = FAIL;
            end else begin
              nState  = ENTER;
              nTarget = rx_exit_to;
            end
          end
        end else if (expire) begin
          // finish on the expiry cycle takes the branch above
          toInc   = 1'b1;
          nState  = ENTER;
          nTarget = DETECT_QUIET;
        end
      end
      LINKUP: begin
        if (rx_finish && legal && rx_exit_to != L0) begin
          wrRate  = rx_write_rate_id;
          wrLink  = rx_write_link_number;
          nState  = ENTER;
          nTarget = rx_exit_to;
        end
      end
      FAIL: nState = FAIL;
      default: nState = IDLE;
    endcase
    if (!enable) begin
      nState = IDLE;
      wrRate = 1'b0;
      wrLink = 1'b0;
      toInc  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      hops                   <= '0;
      substate               <= DETECT_QUIET;
      rx_reset               <= 1'b1;
      rate_id                <= '0;
      link_number            <= '0;
      upconfigure_capability <= 1'b0;
      link_up                <= 1'b0;
      busy                   <= 1'b0;
      error                  <= 1'b0;
      timeout_count          <= '0;
    end else begin
      state    <= nState;
      hops     <= nHops;
      rx_reset <= nState inside {IDLE, ENTER, FAIL};
      link_up  <= nState == LINKUP;
      busy     <= nState inside {ENTER, WAIT};
      unique case (1'b1)
        nState == ENTER:  substate <= nTarget;
        nState == LINKUP: substate <= L0;
        nState == WAIT:   substate <= substate;
        default:          substate <= DETECT_QUIET;
      endcase
      // error is only ever set while heading into FAIL
      if (nState == FAIL) begin
        error <= 1'b1;
      end else if (nState == IDLE) begin
        error <= 1'b0;
      end
      if (wrRate) begin
        rate_id                <= rx_rate_id;
        upconfigure_capability <= rx_upcfg;
      end
      if (wrLink) begin
        link_number <= rx_link_number;
      end
      if (toInc && timeout_count != '1) begin
        timeout_count <= timeout_count + CNT_W'(1);
      end
    end
  end

endmodule
